game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Central run-control FSM for the dinosaur game, clocked by clk_display.
- Turns decoded keyboard presses into start and jump commands.
- Aligns game start to vertical blanking.
- Qualifies dinosaur/cactus pixel overlap into a game-over event.
- Schedules scroll speed from the BCD score.
- Drives game_status, stop_s, speed, start and jump pulses, and the LED pattern consumed by the Jump, Cactus, Ground, Score and audio blocks.

Parameters:
SPEED_MIN, 4'd2, speed after start and after reset.
SPEED_MAX, 4'd9, saturation limit for speed.
COLL_MIN, 8, overlapping pixels within one frame required to declare a collision.
JUMP_COOLDOWN, 3, frames after a jump pulse during which further jump presses are ignored.

Ports:
clk_display  in   1   pixel-domain clock
rst_d        in   1   reset (asynchronous, active-high)
key_valid    in   1   one-cycle strobe from keyboard decoder
key_hit      in   1   last key is space or right_1 and is pressed (qualified by key_valid)
vs           in   1   VGA vertical sync; 0 = blanking
px_dinosaur  in   1   dinosaur pixel active at current scan position
px_cactus    in   1   cactus pixel active at current scan position
score        in   16  BCD score, 4 digits
game_status  out  1   1 while running
stop_s       out  1   1 after game over, until next start or reset
start_pulse  out  1   one-cycle start strobe to Jump/Cactus/Score
jump_req     out  1   one-cycle jump strobe to Jump
speed        out  4   scroll speed to Ground/Cactus
led          out  16  status pattern

Behaviour:
- Reset (rst_d=1, async): state=IDLE; game_status=0, stop_s=0, start_pulse=0, jump_req=0, speed=SPEED_MIN, led=16'h0000. Internal: vs_q=1, overlap count=0, cooldown=0, last hundreds digit=0.
- press = key_valid & key_hit. frame_tick = vs_q & ~vs (falling edge of vs), registered every cycle.
- All outputs are registered; the FSM uses 2-bit state.
- IDLE (00):
  - game_status=0.
  - press -> start_pulse=1 for one cycle; speed=SPEED_MIN; go ARMED.
- ARMED (01):
  - Stay until vs==0; then go RUN with game_status=1 on the next cycle.
  - Presses are ignored.
  - A start issued during blanking enters RUN one cycle after ARMED.
- RUN (10):
  - Overlap counter increments (saturating at 255) each cycle with vs==1 & px_dinosaur & px_cactus; it clears on frame_tick.
  - When the count reaches COLL_MIN -> go OVER; game_status=0; stop_s=1.
  - Press with cooldown==0 -> jump_req=1 for one cycle; cooldown=JUMP_COOLDOWN.
  - Cooldown decrements on frame_tick, saturating at 0.
  - Collision and press in the same cycle: collision wins; no jump_req.
  - Speed: when score[11:8] differs from the registered last value, speed=min(speed+1, SPEED_MAX) and last value updates. A hundreds-digit change in the same cycle as a collision still updates speed.
- OVER (11):
  - stop_s=1; game_status=0; speed holds.
  - press -> start_pulse=1; stop_s=0; cooldown=0; last hundreds digit=0; speed=SPEED_MIN; go ARMED.
- led:
  - IDLE/ARMED = 16'h0000.
  - RUN = 16'hFFFF.
  - OVER = 16'h00FF.
- Reset mid-operation, in any state: returns immediately to the reset values above; a pending pulse is dropped.
- A press on the same cycle as reset release is ignored.

Optional Feature:
Macro GAME_SEQ_PAUSE_EN.
- Defined:
  - Adds input pause_hit (1 bit, qualified by key_valid) and state PAUSE (3-bit state encoding).
  - RUN + pause press -> PAUSE: game_status=0, stop_s=0, led=16'hF0F0, overlap count and cooldown frozen.
  - PAUSE + pause press -> ARMED (resume aligned to blanking); speed is preserved, no start_pulse.
- Undefined: no pause_hit port; 2-bit encoding; PAUSE unreachable.

Decomposition:
Package game_pkg holds:
- the state enum (IDLE, ARMED, RUN, OVER, PAUSE);
- LED pattern constants (LED_OFF, LED_RUN, LED_OVER, LED_PAUSE);
- default SPEED_MIN/SPEED_MAX.

One sub-module, frame_tick_gen, implements the vs falling-edge detector and produces frame_tick and in_active (vs==1). Everything else stays in game_sequencer.

Test Plan:
1. Reset then release; press with vs=1 -> start_pulse=1 one cycle, state ARMED, game_status=0; drive vs=0 -> game_status=1 next cycle, led=16'hFFFF.
2. RUN, 7 overlapping pixels in one frame, then frame_tick, then 7 more -> no game over. 8 in one frame -> game_status=0, stop_s=1, led=16'h00FF on the cycle after the 8th.
3. RUN, press -> jump_req one cycle. Presses within the next 3 frame_ticks -> no jump_req. Press after the 3rd tick -> jump_req.
4. RUN, score 16'h0099 -> 16'h0100 -> speed 2->3. Repeat to 16'h0900 -> speed saturates at 9.
5. Press and 8th overlap pixel in the same cycle -> OVER, jump_req stays 0. Then press in OVER -> start_pulse, stop_s=0, speed=2.
6. Assert rst_d mid-RUN with cooldown=2 and speed=5 -> all outputs reset asynchronously, state IDLE.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the dinosaur game run-control sequencer.
// GAME_SEQ_PAUSE_EN widens the state encoding to 3 bits and adds PAUSE.
package game_pkg;

`ifdef GAME_SEQ_PAUSE_EN
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    ARMED = 3'b001,
    RUN   = 3'b010,
    OVER  = 3'b011,
    PAUSE = 3'b100
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    RUN   = 2'b10,
    OVER  = 2'b11
  } state_e;
`endif

  localparam logic [15:0] LED_OFF   = 16'h0000;
  localparam logic [15:0] LED_RUN   = 16'hFFFF;
  localparam logic [15:0] LED_OVER  = 16'h00FF;
  localparam logic [15:0] LED_PAUSE = 16'hF0F0;

  localparam logic [3:0] SPEED_MIN_DEF = 4'd2;
  localparam logic [3:0] SPEED_MAX_DEF = 4'd9;

  function automatic logic [15:0] led_pattern(input state_e s);
    logic [15:0] pat;
    pat = LED_OFF;
    case (s)
      RUN:     pat = LED_RUN;
      OVER:    pat = LED_OVER;
`ifdef GAME_SEQ_PAUSE_EN
      PAUSE:   pat = LED_PAUSE;
`endif
      default: pat = LED_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Keyboard/video/score inputs and run-control outputs of the game sequencer.
// GAME_SEQ_PAUSE_EN adds the pause_hit key qualifier.
interface game_sequencer_if;
  logic        key_valid;
  logic        key_hit;
  logic        vs;
  logic        px_dinosaur;
  logic        px_cactus;
  logic [15:0] score;
`ifdef GAME_SEQ_PAUSE_EN
  logic        pause_hit;
`endif
  logic        game_status;
  logic        stop_s;
  logic        start_pulse;
  logic        jump_req;
  logic [3:0]  speed;
  logic [15:0] led;

  modport master (
    output key_valid, key_hit, vs, px_dinosaur, px_cactus, score,
`ifdef GAME_SEQ_PAUSE_EN
    output pause_hit,
`endif
    input  game_status, stop_s, start_pulse, jump_req, speed, led
  );

  modport slave (
    input  key_valid, key_hit, vs, px_dinosaur, px_cactus, score,
`ifdef GAME_SEQ_PAUSE_EN
    input  pause_hit,
`endif
    output game_status, stop_s, start_pulse, jump_req, speed, led
  );
endinterface

// File: rtl/game_sequencer_frame_tick_gen.sv
// Vertical-sync falling-edge detector: frame_tick is combinational off one vs register.
// Latency: frame_tick same cycle as vs falls; no backpressure.
module frame_tick_gen (
  input  logic clk_display,
  input  logic rst_d,
  input  logic vs,
  output logic frame_tick,
  output logic in_active
);
  logic vs_q;

  always_ff @(posedge clk_display or posedge rst_d) begin
    if (rst_d) begin
      vs_q <= 1'b1;
    end else begin
      vs_q <= vs;
    end
  end

  assign frame_tick = vs_q & ~vs;
  assign in_active  = vs;
endmodule

// File: rtl/game_sequencer.sv
// Run-control FSM for the dinosaur game (start/jump/collision/speed); optional pause via GAME_SEQ_PAUSE_EN.
// Latency: all outputs registered, one cycle after the deciding input; no backpressure.
module game_sequencer
  import game_pkg::*;
#(
  parameter logic [3:0]  SPEED_MIN     = SPEED_MIN_DEF,
  parameter logic [3:0]  SPEED_MAX     = SPEED_MAX_DEF,
  parameter int unsigned COLL_MIN      = 8,
  parameter int unsigned JUMP_COOLDOWN = 3
) (
  input  logic            clk_display,
  input  logic            rst_d,
  game_sequencer_if.slave bus
);
  localparam logic [3:0] COOL_INIT = 4'(JUMP_COOLDOWN);

  state_e      state_q, state_d;
  logic        frame_tick, in_active;
  logic        ready_q;
  logic [7:0]  ovl_q, ovl_d;
  logic [3:0]  cool_q, cool_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  speed_q, speed_d;
  logic        start_q, start_d;
  logic        jump_q, jump_d;
  logic        game_status_q, stop_s_q;
  logic [15:0] led_q;
  logic        press, pause_press, hit, coll, frozen;
  logic        unused_score;

  frame_tick_gen u_frame (
    .clk_display (clk_display),
    .rst_d       (rst_d),
    .vs          (bus.vs),
    .frame_tick  (frame_tick),
    .in_active   (in_active)
  );

  // ready_q masks a key held across reset release
  assign press = bus.key_valid & bus.key_hit & ready_q;
`ifdef GAME_SEQ_PAUSE_EN
  assign pause_press = bus.key_valid & bus.pause_hit & ready_q;
  assign frozen      = (state_q == PAUSE);
`else
  assign pause_press = 1'b0;
  assign frozen      = 1'b0;
`endif
  assign hit  = in_active & bus.px_dinosaur & bus.px_cactus;
  assign coll = hit && ((32'(ovl_q) + 32'd1) >= COLL_MIN);
  assign unused_score = ^{bus.score[15:12], bus.score[7:0]};

  always_comb begin
    state_d = state_q;
    ovl_d   = ovl_q;
    cool_d  = cool_q;
    hund_d  = hund_q;
    speed_d = speed_q;
    start_d = 1'b0;
    jump_d  = 1'b0;

    if (frame_tick && !frozen) begin
      ovl_d = 8'd0;
      if (cool_q != 4'd0) cool_d = cool_q - 4'd1;
    end

    case (state_q)
      IDLE: begin
        if (press) begin
          start_d = 1'b1;
          speed_d = SPEED_MIN;
          ovl_d   = 8'd0;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (!in_active) state_d = RUN;
      end
      RUN: begin
        if (hit && ovl_q != 8'hFF) ovl_d = ovl_q + 8'd1;
        // speed follows the hundreds digit even on the collision cycle
        if (bus.score[11:8] != hund_q) begin
          hund_d  = bus.score[11:8];
          speed_d = (speed_q >= SPEED_MAX) ? SPEED_MAX : speed_q + 4'd1;
        end
        if (coll) begin
          state_d = OVER;
`ifdef GAME_SEQ_PAUSE_EN
        end else if (pause_press) begin
          state_d = PAUSE;
`endif
        end else if (press && cool_q == 4'd0) begin
          jump_d = 1'b1;
          cool_d = COOL_INIT;
        end
      end
      OVER: begin
        if (press) begin
          start_d = 1'b1;
          cool_d  = 4'd0;
          hund_d  = 4'd0;
          speed_d = SPEED_MIN;
          ovl_d   = 8'd0;
          state_d = ARMED;
        end
      end
`ifdef GAME_SEQ_PAUSE_EN
      PAUSE: begin
        if (pause_press) state_d = ARMED;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_display or posedge rst_d) begin
    if (rst_d) begin
      state_q       <= IDLE;
      ready_q       <= 1'b0;
      ovl_q         <= 8'd0;
      cool_q        <= 4'd0;
      hund_q        <= 4'd0;
      speed_q       <= SPEED_MIN;
      start_q       <= 1'b0;
      jump_q        <= 1'b0;
      game_status_q <= 1'b0;
      stop_s_q      <= 1'b0;
      led_q         <= LED_OFF;
    end else begin
      state_q       <= state_d;
      ready_q       <= 1'b1;
      ovl_q         <= ovl_d;
      cool_q        <= cool_d;
      hund_q        <= hund_d;
      speed_q       <= speed_d;
      start_q       <= start_d;
      jump_q        <= jump_d;
      game_status_q <= (state_d == RUN);
      stop_s_q      <= (state_d == OVER);
      led_q         <= led_pattern(state_d);
    end
  end

  assign bus.game_status = game_status_q;
  assign bus.stop_s      = stop_s_q;
  assign bus.start_pulse = start_q;
  assign bus.jump_req    = jump_q;
  assign bus.speed       = speed_q;
  assign bus.led         = led_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed and random stimulus for game_sequencer, checked every cycle against a rule-level model.
module tb_game_sequencer;
  localparam int MD_IDLE = 0, MD_ARMED = 1, MD_RUN = 2, MD_OVER = 3;
  localparam int COLL_N = 8, COOL_N = 3, SPD_LO = 2, SPD_HI = 9;

  logic clk_display = 1'b0;
  logic rst_d;
  game_sequencer_if bus();

  game_sequencer dut (
    .clk_display (clk_display),
    .rst_d       (rst_d),
    .bus         (bus)
  );

  always #5 clk_display = ~clk_display;

  int total = 0;
  int bad   = 0;
  int jumps_seen = 0;
  int j0, act_left, blank_left;

  // model: game mode, overlap pixels this frame, frames of jump lockout left,
  // hundreds digit last seen, speed, previous vs, key-ready after reset
  int m_mode, m_ovl, m_cool, m_hund, m_speed;
  bit m_vs_prev, m_ready, e_start, e_jump;

  function automatic logic [15:0] led_of(input int md);
    if (md == MD_RUN) return 16'hFFFF;
    if (md == MD_OVER) return 16'h00FF;
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m_mode = MD_IDLE; m_ovl = 0; m_cool = 0; m_hund = 0; m_speed = SPD_LO;
    m_vs_prev = 1'b1; m_ready = 1'b0; e_start = 1'b0; e_jump = 1'b0;
  endtask

  task automatic model_edge();
    bit press, new_frame, both;
    int nm, no, nc, nh, ns;
    press     = bus.key_valid && bus.key_hit && m_ready;
    new_frame = m_vs_prev && !bus.vs;
    both      = bus.vs && bus.px_dinosaur && bus.px_cactus;
    nm = m_mode; no = m_ovl; nc = m_cool; nh = m_hund; ns = m_speed;
    e_start = 1'b0; e_jump = 1'b0;
    if (new_frame) begin
      no = 0;
      nc = (m_cool > 0) ? m_cool - 1 : 0;
    end
    if (m_mode == MD_IDLE || m_mode == MD_OVER) begin
      if (press) begin
        e_start = 1'b1; nm = MD_ARMED; ns = SPD_LO; no = 0;
        if (m_mode == MD_OVER) begin nc = 0; nh = 0; end
      end
    end else if (m_mode == MD_ARMED) begin
      if (!bus.vs) nm = MD_RUN;
    end else begin
      if (both) no = (m_ovl < 255) ? m_ovl + 1 : 255;
      if (int'(bus.score[11:8]) != m_hund) begin
        nh = int'(bus.score[11:8]);
        ns = (m_speed + 1 > SPD_HI) ? SPD_HI : m_speed + 1;
      end
      if (both && m_ovl + 1 >= COLL_N) nm = MD_OVER;
      else if (press && m_cool == 0) begin e_jump = 1'b1; nc = COOL_N; end
    end
    m_mode = nm; m_ovl = no; m_cool = nc; m_hund = nh; m_speed = ns;
    m_vs_prev = bus.vs; m_ready = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("start_pulse", 16'(bus.start_pulse), 16'(e_start));
    chk("jump_req",    16'(bus.jump_req),    16'(e_jump));
    chk("game_status", 16'(bus.game_status), 16'(m_mode == MD_RUN));
    chk("stop_s",      16'(bus.stop_s),      16'(m_mode == MD_OVER));
    chk("speed",       16'(bus.speed),       16'(m_speed));
    chk("led",         bus.led,              led_of(m_mode));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_display);
    #1;
    if (bus.jump_req) jumps_seen++;
    check_all();
  endtask

  task automatic press_tick();
    bus.key_valid = 1'b1; bus.key_hit = 1'b1;
    tick();
    bus.key_valid = 1'b0; bus.key_hit = 1'b0;
  endtask

  // one active period (optionally with n_ovl overlapping pixels and a press) then two blanking lines
  task automatic frame(input int n_ovl, input int active, input int press_at);
    bus.vs = 1'b1;
    for (int i = 0; i < active; i++) begin
      bus.px_dinosaur = (i < n_ovl);
      bus.px_cactus   = (i < n_ovl) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.key_valid   = (i == press_at);
      bus.key_hit     = (i == press_at);
      tick();
    end
    bus.key_valid = 1'b0; bus.key_hit = 1'b0;
    bus.vs = 1'b0; bus.px_dinosaur = 1'b1; bus.px_cactus = 1'b1;
    tick();
    tick();
    bus.vs = 1'b1; bus.px_dinosaur = 1'b0; bus.px_cactus = 1'b0;
  endtask

  initial begin
    rst_d = 1'b1;
    bus.key_valid = 1'b0; bus.key_hit = 1'b0; bus.vs = 1'b1;
    bus.px_dinosaur = 1'b0; bus.px_cactus = 1'b0; bus.score = 16'h0000;
`ifdef GAME_SEQ_PAUSE_EN
    bus.pause_hit = 1'b0;
`endif
    model_reset();
    #3;
    check_all();
    @(posedge clk_display); #1;

    // key held while reset releases must be ignored
    bus.key_valid = 1'b1; bus.key_hit = 1'b1; rst_d = 1'b0;
    tick();
    chk("press_at_release", 16'(bus.start_pulse), 16'd0);
    bus.key_valid = 1'b0; bus.key_hit = 1'b0;
    tick();

    press_tick();
    chk("start_first", 16'(bus.start_pulse), 16'd1);
    press_tick();
    chk("armed_ignores_press", 16'(bus.start_pulse), 16'd0);
    tick();
    bus.vs = 1'b0;
    tick();
    chk("run_status", 16'(bus.game_status), 16'd1);
    chk("run_led", bus.led, 16'hFFFF);

    frame(7, 10, -1);
    frame(7, 10, -1);
    chk("no_over_7_7", 16'(bus.stop_s), 16'd0);
    bus.vs = 1'b1; bus.px_dinosaur = 1'b1; bus.px_cactus = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("seven_still_run", 16'(bus.game_status), 16'd1);
    tick();
    chk("eighth_over_status", 16'(bus.game_status), 16'd0);
    chk("eighth_over_stop", 16'(bus.stop_s), 16'd1);
    chk("eighth_over_led", bus.led, 16'h00FF);
    bus.px_dinosaur = 1'b0; bus.px_cactus = 1'b0;

    press_tick();
    bus.vs = 1'b0;
    tick();
    bus.vs = 1'b1;
    press_tick();
    chk("jump_first", 16'(bus.jump_req), 16'd1);
    tick();
    chk("jump_one_cycle", 16'(bus.jump_req), 16'd0);
    j0 = jumps_seen;
    frame(0, 4, 1);
    frame(0, 4, 1);
    frame(0, 4, 1);
    chk("cooldown_blocks", 16'(jumps_seen - j0), 16'd0);
    frame(0, 4, 1);
    chk("cooldown_expired", 16'(jumps_seen - j0), 16'd1);

    bus.score = 16'h0099; tick();
    bus.score = 16'h0100; tick();
    chk("speed_step", 16'(bus.speed), 16'd3);
    for (int h = 2; h <= 9; h++) begin
      bus.score = 16'(h << 8);
      tick();
    end
    chk("speed_saturate", 16'(bus.speed), 16'd9);

    frame(0, 3, -1);
    frame(0, 3, -1);
    frame(0, 3, -1);
    bus.px_dinosaur = 1'b1; bus.px_cactus = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    press_tick();
    chk("coll_beats_jump", 16'(bus.jump_req), 16'd0);
    chk("coll_beats_jump_stop", 16'(bus.stop_s), 16'd1);
    bus.px_dinosaur = 1'b0; bus.px_cactus = 1'b0;
    bus.score = 16'h0000;
    press_tick();
    chk("restart_start", 16'(bus.start_pulse), 16'd1);
    chk("restart_stop", 16'(bus.stop_s), 16'd0);
    chk("restart_speed", 16'(bus.speed), 16'd2);

    bus.vs = 1'b0;
    tick();
    bus.vs = 1'b1;
    bus.score = 16'h0100; tick();
    bus.score = 16'h0200; tick();
    bus.score = 16'h0300; tick();
    press_tick();
    frame(0, 3, -1);
    chk("pre_reset_speed", 16'(bus.speed), 16'd5);

    // asynchronous reset between clock edges
    #3 rst_d = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk_display); #1;
    check_all();
    rst_d = 1'b0;
    tick();

    act_left = 10; blank_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (bus.vs) begin
        if (act_left == 0) begin bus.vs = 1'b0; blank_left = $urandom_range(1, 3); end
        else act_left--;
      end else begin
        if (blank_left == 0) begin bus.vs = 1'b1; act_left = $urandom_range(5, 40); end
        else blank_left--;
      end
      bus.key_valid   = ($urandom_range(0, 7) == 0);
      bus.key_hit     = 1'($urandom_range(0, 1));
      bus.px_dinosaur = ($urandom_range(0, 2) == 0);
      bus.px_cactus   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 30) == 0) bus.score = {4'd0, 4'($urandom_range(0, 9)), 8'h00};
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
